divisor_sequencial: RTL and testbench

- Unsigned sequential divider using restoring shift-and-subtract. It is the inverse datapath of the team's add-and-accumulate multiplier.
- Takes a dividend and a divisor and produces a quotient and a remainder, resolving one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit and shares its operand width and its start/done style of control.

---
 rtl/divisor_pkg.sv | 12 +
 rtl/divisor_passo.sv | 34 +++
 rtl/divisor_sequencial.sv | 98 +++++++++
 tb/tb_divisor_sequencial.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider: default width and FSM states.
package divisor_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divisor_passo.sv
// One restoring shift-and-subtract iteration: shift the next dividend bit into R and
// keep the difference only when it does not go negative.
module divisor_passo
  import divisor_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] t;
  logic           unused_r_msb;

  // R never exceeds divisor-1 between iterations, so its top bit is always 0 here.
  assign unused_r_msb = r[WIDTH];

  always_comb begin
    shifted = {r[WIDTH-1:0], q[WIDTH-1]};
    t       = shifted - {1'b0, divisor};
    if (!t[WIDTH]) begin
      r_next = t;
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = shifted;
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divisor_sequencial.sv
// Unsigned sequential restoring divider: one quotient bit per clock, start/done handshake,
// results held until the next completed operation.
module divisor_sequencial
  import divisor_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  div_state_t       state, state_next;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;

  divisor_passo #(.WIDTH(WIDTH)) u_passo (
    .r       (r_reg),
    .q       (q_reg),
    .divisor (dvsr),
    .r_next  (r_next),
    .q_next  (q_next)
  );

  assign last_iter = (count == CW'(1));
  assign busy      = (state == ST_CALC);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (divisor == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvsr        <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            dvsr  <= divisor;
            r_reg <= '0;
            q_reg <= dividend;
            count <= CW'(WIDTH);
            // Division by zero bypasses CALC and reports directly.
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count - CW'(1);
          if (last_iter) begin
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: scoreboard of expected results checked on done.
module tb_divisor_sequencial;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  divisor_sequencial #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 8'd0) begin
      e.q = 8'hFF;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Issue one operation from IDLE, wait (bounded) for done, compare against the scoreboard.
  // Returns the observed latency in cycles after the accepting edge (0 on timeout).
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    exp_t e;
    int   c;
    logic [15:0] recon;
    sb.push_back(model(a, b));
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    c = 1;
    while (!done && c < 20) begin
      @(negedge clk);
      c++;
    end
    e = sb.pop_front();
    lat = 0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL done_timeout %0d/%0d: done=%b after %0d cycles, required 1", a, b, done, c);
    end else begin
      lat = c;
      n_vec++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
        n_err++;
        $display("FAIL result %0d/%0d: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                 e.a, e.b, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
      if (!div_by_zero) begin
        recon = 16'(quotient) * 16'(e.b) + 16'(remainder);
        n_vec++;
        if (recon !== 16'(e.a) || !(remainder < e.b)) begin
          n_err++;
          $display("FAIL invariant %0d/%0d: q*d+r=%0d r=%0d, required %0d with r<%0d",
                   e.a, e.b, recon, remainder, e.a, e.b);
        end
      end
    end
    @(negedge clk);  // DONE -> IDLE before the next start
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timing();
    exp_t e;
    int   busy_cnt, done_at;
    e = model(8'd200, 8'd7);
    sb.push_back(e);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; done_at = 0;
    for (int c = 1; c <= 12; c++) begin
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = c;
      @(negedge clk);
    end
    e = sb.pop_front();
    n_vec++;
    if (done_at !== 9) begin
      n_err++;
      $display("FAIL latency_200_7: done at cycle %0d, required 9", done_at);
    end
    n_vec++;
    if (busy_cnt !== 8) begin
      n_err++;
      $display("FAIL busy_cycles_200_7: busy for %0d cycles, required 8", busy_cnt);
    end
    n_vec++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
      n_err++;
      $display("FAIL result_200_7: got q=%0d r=%0d dbz=%b, required q=28 r=4 dbz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] as[5] = '{8'd255, 8'd5, 8'd0, 8'd255, 8'd1};
    logic [7:0] bs[5] = '{8'd1, 8'd9, 8'd13, 8'd255, 8'd2};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_div(as[i], bs[i], lat);
      n_vec++;
      if (lat !== 9) begin
        n_err++;
        $display("FAIL latency %0d/%0d: %0d, required 9", as[i], bs[i], lat);
      end
    end
    // Results must hold through IDLE with start low.
    repeat (6) @(negedge clk);
    n_vec++;
    if (quotient !== 8'd0 || remainder !== 8'd1 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL hold_idle: q=%0d r=%0d done=%b busy=%b, required q=0 r=1 done=0 busy=0",
               quotient, remainder, done, busy);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    do_div(8'd77, 8'd0, lat);
    n_vec++;
    if (lat !== 1) begin
      n_err++;
      $display("FAIL latency_div0: %0d, required 1", lat);
    end
    do_div(8'd10, 8'd3, lat);
  endtask

  task automatic test_abort();
    int lat, seen_done;
    start = 1'b1; dividend = 8'd100; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);  // now in the 4th CALC cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL abort_reset: busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) seen_done++;
      @(negedge clk);
    end
    n_vec++;
    if (seen_done !== 0) begin
      n_err++;
      $display("FAIL abort_quiet: %0d busy/done cycles after reset, required 0", seen_done);
    end
    do_div(8'd100, 8'd3, lat);
  endtask

  task automatic test_start_spam();
    exp_t e;
    int   pulses, after;
    e = model(8'd150, 8'd11);
    sb.push_back(e);
    start = 1'b1; dividend = 8'd150; divisor = 8'd11;
    pulses = 0;
    for (int c = 0; c < 20 && pulses == 0; c++) begin
      @(negedge clk);
      dividend = 8'($urandom); divisor = 8'($urandom);
      if (done) begin
        pulses++;
        start = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
          n_err++;
          $display("FAIL spam_result: got q=%0d r=%0d dbz=%b, required q=13 r=7 dbz=0",
                   quotient, remainder, div_by_zero);
        end
      end
    end
    start = 1'b0;
    after = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done || busy) after++;
    end
    n_vec++;
    if (pulses !== 1 || after !== 0) begin
      n_err++;
      $display("FAIL spam_single_done: pulses=%0d extra_activity=%0d, required 1 and 0", pulses, after);
    end
    if (pulses == 0) void'(sb.pop_front());
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < 3000; i++) begin
      do_div(8'($urandom), (i % 17 == 0) ? 8'd0 : 8'($urandom), lat);
    end
    for (int a = 0; a < 256; a += 51) begin
      for (int b = 0; b < 256; b += 15) begin
        do_div(8'(a), 8'(b), lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_boundaries();
    test_div_zero();
    test_abort();
    test_start_spam();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
